// File: rtl/tile_pkg.sv
// Shared constants and helpers for the tile spawner: LFSR tap masks, ASCII base, clog2.
// Tap masks put tap n on bit n-1 so they can be ANDed directly with the LFSR state.
package tile_pkg;

    localparam logic [7:0] ASCII_BASE = 8'h41;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Maximal-length Fibonacci taps for widths 8..16.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

endpackage

// File: rtl/tile_fifo.sv
// Show-ahead FIFO: head is visible combinationally, a write appears at the head the next cycle.
// Push is accepted when not full or when a pop happens the same cycle; otherwise it is ignored.
module tile_fifo import tile_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/tile_spawner.sv
// Paced random rail spawner; rail/rail_valid one cycle after the tick, byte queued the same tick.
// tx side is valid/ready; spawns while the queue is full are dropped and flagged sticky in overflow.
module tile_spawner import tile_pkg::*; #(
    parameter int          TICK_DIV   = 10_000_000,
    parameter int          NUM_RAILS  = 4,
    parameter int          LFSR_W     = 16,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          FIFO_DEPTH = 4,
    localparam int         RAIL_W     = (clog2(NUM_RAILS) < 1) ? 1 : clog2(NUM_RAILS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              no_repeat,
    output logic [RAIL_W-1:0] rail,
    output logic              rail_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              overflow
);

    localparam int                CNT_W    = clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [RAIL_W:0]   NR       = (RAIL_W+1)'(NUM_RAILS);
    localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(lfsr_taps(LFSR_W));

    logic [LFSR_W-1:0] r_lfsr;
    logic [CNT_W-1:0]  r_cnt;
    logic [RAIL_W-1:0] r_rail;
    logic              r_rail_vld;
    logic              r_ovf;

    logic              w_fb;
    logic [LFSR_W-1:0] w_lfsr_nxt;
    logic              w_tick;
    logic [RAIL_W-1:0] w_raw;
    logic [RAIL_W-1:0] w_fold;
    logic [RAIL_W:0]   w_inc;
    logic [RAIL_W-1:0] w_step;
    logic [RAIL_W-1:0] w_cand;
    logic [7:0]        w_byte;
    logic [7:0]        w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    assign w_fb       = ^(r_lfsr & TAPS);
    assign w_lfsr_nxt = (r_lfsr == '0) ? LFSR_W'(1) : {r_lfsr[LFSR_W-2:0], w_fb};
    assign w_tick     = enable && (r_cnt == CNT_LAST);

    // Raw draw is below 2*NUM_RAILS, so a single conditional subtraction folds it into range.
    assign w_raw  = r_lfsr[RAIL_W-1:0];
    assign w_fold = ({1'b0, w_raw} >= NR) ? (w_raw - NR[RAIL_W-1:0]) : w_raw;
    assign w_inc  = {1'b0, w_fold} + (RAIL_W+1)'(1);
    assign w_step = (w_inc == NR) ? '0 : w_inc[RAIL_W-1:0];
    assign w_cand = (no_repeat && (w_fold == r_rail)) ? w_step : w_fold;
    assign w_byte = ASCII_BASE + 8'(w_cand);

    assign w_pop      = !w_empty && tx_ready;
    assign tx_valid   = !w_empty;
    assign tx_data    = w_empty ? 8'h00 : w_head;
    assign rail       = r_rail;
    assign rail_valid = r_rail_vld;
    assign overflow   = r_ovf;

    // r_rail doubles as last_rail: both are only ever written together with the same value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr     <= SEED[LFSR_W-1:0];
            r_cnt      <= '0;
            r_rail     <= '0;
            r_rail_vld <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_lfsr     <= w_lfsr_nxt;
            r_rail_vld <= w_tick;
            if (enable) r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
            if (w_tick) r_rail <= w_cand;
            if (w_tick && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    tile_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset_n),
        .i_push     (w_tick),
        .i_push_dat (w_byte),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

endmodule

// File: tb/tb_tile_spawner.sv
// Four spawner configurations run against a cycle-level reference model of the spawn rules.
// Instance 0 also has its byte queue modelled with a SystemVerilog queue.
module tb_tile_spawner;

    localparam int TDV [4] = '{4, 2, 2, 3};
    localparam int NRV [4] = '{4, 3, 2, 4};
    localparam int LWV [4] = '{16, 16, 9, 16};
    localparam int DEPTH_A = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] en, nrp, rdy;
    logic [3:0] rvld, txv, ovf;
    logic [7:0] txd [4];
    logic [1:0] rail_a, rail_b, rail_d;
    logic [0:0] rail_c;
    logic [2:0] rail_o [4];

    always #5 clk = ~clk;

    assign rail_o[0] = {1'b0, rail_a};
    assign rail_o[1] = {1'b0, rail_b};
    assign rail_o[2] = {2'b00, rail_c};
    assign rail_o[3] = {1'b0, rail_d};

    tile_spawner #(.TICK_DIV(4), .NUM_RAILS(4), .LFSR_W(16), .SEED(16'hACE1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset_n(reset_n), .enable(en[0]), .no_repeat(nrp[0]), .rail(rail_a),
        .rail_valid(rvld[0]), .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(rdy[0]), .overflow(ovf[0]));
    tile_spawner #(.TICK_DIV(2), .NUM_RAILS(3), .LFSR_W(16), .SEED(16'hACE1), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .reset_n(reset_n), .enable(en[1]), .no_repeat(nrp[1]), .rail(rail_b),
        .rail_valid(rvld[1]), .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(rdy[1]), .overflow(ovf[1]));
    tile_spawner #(.TICK_DIV(2), .NUM_RAILS(2), .LFSR_W(9), .SEED(16'h01A5), .FIFO_DEPTH(2)) u_c (
        .clk(clk), .reset_n(reset_n), .enable(en[2]), .no_repeat(nrp[2]), .rail(rail_c),
        .rail_valid(rvld[2]), .tx_data(txd[2]), .tx_valid(txv[2]), .tx_ready(rdy[2]), .overflow(ovf[2]));
    tile_spawner #(.TICK_DIV(3), .NUM_RAILS(4), .LFSR_W(16), .SEED(16'h0000), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .reset_n(reset_n), .enable(en[3]), .no_repeat(nrp[3]), .rail(rail_d),
        .rail_valid(rvld[3]), .tx_data(txd[3]), .tx_valid(txv[3]), .tx_ready(rdy[3]), .overflow(ovf[3]));

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_lfsr [4];
    int          m_cnt  [4];
    int          m_rail [4];
    bit          m_vld  [4];
    bit          m_ovf;
    logic [7:0]  mq [$];
    bit          b_seen [3];
    bit          c_alt;
    int          c_prev;
    int          c_rep;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference LFSR from the tap table: shift left, XOR of taps enters at bit 0.
    function automatic logic [15:0] ref_next(input logic [15:0] s, input int w);
        logic        fb;
        logic [15:0] mask;
        mask = (w == 16) ? 16'hFFFF : 16'((32'd1 << w) - 1);
        if ((s & mask) == 16'h0) return 16'h0001;
        if (w == 9) fb = s[8] ^ s[4];
        else        fb = s[15] ^ s[14] ^ s[12] ^ s[3];
        return ((s << 1) | {15'h0, fb}) & mask;
    endfunction

    function automatic int draw(input logic [15:0] l, input int nr, input int last, input bit nore);
        int rw, c;
        rw = (nr <= 2) ? 1 : (nr <= 4) ? 2 : 3;
        c  = int'(l) % (1 << rw);
        if (c >= nr) c -= nr;
        if (nore && c == last) c = (c + 1) % nr;
        return c;
    endfunction

    task automatic reset_model();
        m_lfsr[0] = 16'hACE1;
        m_lfsr[1] = 16'hACE1;
        m_lfsr[2] = 16'h01A5;
        m_lfsr[3] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_rail[i] = 0; m_vld[i] = 1'b0;
        end
        m_ovf = 1'b0;
        mq.delete();
    endtask

    // Advance the model over the current cycle with the present inputs, then check the next cycle.
    task automatic step();
        bit tk;
        bit pop;
        int r;
        for (int i = 0; i < 4; i++) begin
            tk = en[i] && (m_cnt[i] == TDV[i] - 1);
            if (i == 0) begin
                pop = (mq.size() > 0) && rdy[0];
                if (pop) void'(mq.pop_front());
            end
            if (tk) begin
                r = draw(m_lfsr[i], NRV[i], m_rail[i], nrp[i]);
                m_rail[i] = r;
                if (i == 0) begin
                    if (mq.size() < DEPTH_A) mq.push_back(8'(8'h41 + r));
                    else m_ovf = 1'b1;
                end
            end
            m_vld[i] = tk;
            if (en[i]) m_cnt[i] = tk ? 0 : m_cnt[i] + 1;
            m_lfsr[i] = ref_next(m_lfsr[i], LWV[i]);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rail_valid[%0d]", i), 32'(rvld[i]), 32'(m_vld[i]));
            chk($sformatf("rail[%0d]", i), 32'(rail_o[i]), 32'(m_rail[i]));
        end
        chk("tx_valid", 32'(txv[0]), 32'(mq.size() > 0));
        chk("tx_data", 32'(txd[0]), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
        chk("overflow", 32'(ovf[0]), 32'(m_ovf));
        if (rvld[1]) begin
            chk("b_range", 32'(rail_o[1] < 3'd3), 32'd1);
            if (rail_o[1] < 3'd3) b_seen[rail_o[1]] = 1'b1;
        end
        if (rvld[2]) begin
            if (c_prev >= 0) begin
                if (c_alt) chk("c_alternate", 32'(int'(rail_o[2]) != c_prev), 32'd1);
                else if (int'(rail_o[2]) == c_prev) c_rep++;
            end
            c_prev = int'(rail_o[2]);
        end
    endtask

    // Assert reset away from a clock edge, check the flushed state, release on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_rail_valid[%0d]", i), 32'(rvld[i]), 32'd0);
            chk($sformatf("rst_rail[%0d]", i), 32'(rail_o[i]), 32'd0);
        end
        chk("rst_tx_valid", 32'(txv[0]), 32'd0);
        chk("rst_tx_data", 32'(txd[0]), 32'd0);
        chk("rst_overflow", 32'(ovf[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        reset_model();
    endtask

    initial begin
        reset_n = 1'b0;
        en = 4'b0; nrp = 4'b0; rdy = 4'b0;
        c_alt = 1'b0; c_prev = -1; c_rep = 0;
        for (int i = 0; i < 3; i++) b_seen[i] = 1'b0;
        reset_model();

        // Pacing with a ready transmitter; SEED=0 instance shows lock-up escape in its first draw.
        do_reset();
        en = 4'b1111; rdy = 4'b1111;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 3) begin
                chk("a_before_first", 32'(rvld[0]), 32'd0);
                chk("d_first_valid", 32'(rvld[3]), 32'd1);
                chk("d_first_rail", 32'(rail_o[3]), 32'd2);
            end
            if (k == 4) chk("a_first_spawn", 32'(rvld[0]), 32'd1);
        end

        // Backpressure: four queued, fifth dropped, then drain in order.
        do_reset();
        en = 4'b1111; rdy = 4'b1110;
        for (int k = 0; k < 20; k++) step();
        chk("bp_fifth_valid", 32'(rvld[0]), 32'd1);
        chk("bp_overflow", 32'(ovf[0]), 32'd1);
        en[0] = 1'b0; rdy[0] = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("bp_drained", 32'(txv[0]), 32'd0);
        chk("bp_overflow_sticky", 32'(ovf[0]), 32'd1);

        // Reset while bytes are queued and overflow is set.
        en[0] = 1'b1; rdy[0] = 1'b0;
        for (int k = 0; k < 12; k++) step();
        chk("mid_queued", 32'(txv[0]), 32'd1);
        do_reset();
        en = 4'b1111; rdy = 4'b1111;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("post_rst_spawn_%0d", k), 32'(rvld[0]), 32'(k == 4));
        end

        // Enable held low mid-count: counter freezes at 2, spawn follows after the remaining 2.
        do_reset();
        en = 4'b0001;
        for (int k = 0; k < 2; k++) step();
        en[0] = 1'b0;
        for (int k = 0; k < 20; k++) step();
        en[0] = 1'b1;
        step();
        chk("en_resume_early", 32'(rvld[0]), 32'd0);
        step();
        chk("en_resume_spawn", 32'(rvld[0]), 32'd1);

        // Randomised run: 3-rail range, 2-rail no-repeat alternation, random ready/enable on instance 0.
        do_reset();
        en = 4'b1111; rdy = 4'b1111; nrp = 4'b0100;
        c_alt = 1'b1; c_prev = -1;
        for (int k = 0; k < 600; k++) begin
            rdy[0] = 1'($urandom_range(0, 1));
            en[0]  = ($urandom_range(0, 7) != 0);
            nrp[0] = 1'($urandom_range(0, 1));
            nrp[3] = 1'($urandom % 2);
            step();
        end
        for (int i = 0; i < 3; i++) chk($sformatf("b_seen_%0d", i), 32'(b_seen[i]), 32'd1);
        c_alt = 1'b0; nrp[2] = 1'b0; c_rep = 0;
        for (int k = 0; k < 200; k++) begin
            rdy[0] = 1'($urandom_range(0, 1));
            step();
        end
        chk("c_repeats_allowed", 32'(c_rep > 0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tile_spawner.md
# tile_spawner

Parametrised tile-event generator for the Magic Tiles playfield. A free-running LFSR supplies randomness. A programmable tick divider paces spawns, and each spawn picks a rail in 0..NUM_RAILS-1, with an optional no-repeat mode. Every spawn is presented immediately on the rail outputs and is also queued as an ASCII byte ('A'+rail) in a small FIFO. The FIFO drains to the UART transmitter over a valid/ready handshake, so no event is lost while the transmitter is busy, up to FIFO_DEPTH outstanding events.

## Interface
- TICK_DIV, 10_000_000: clk cycles per spawn tick (≥2).
- NUM_RAILS, 4: number of rails, 2..8. RAIL_W = clog2(NUM_RAILS), min 1.
- LFSR_W, 16: LFSR width, 8..16.
- SEED, 16'hACE1: LFSR reset value; low LFSR_W bits are used.
- FIFO_DEPTH, 4: byte queue depth, power of 2, ≥2.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = tick counter runs and spawns occur.
- no_repeat  in  1  1 = a spawn never repeats the previous rail.
- rail  out  RAIL_W  most recent spawned rail.
- rail_valid  out  1  one-cycle pulse per spawn.
- tx_data  out  8  FIFO head byte; 8'h00 when the FIFO is empty.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  UART transmitter accepts tx_data this cycle.
- overflow  out  1  sticky flag: a spawn byte was dropped because the FIFO was full.

## Operation
- **Reset values.** LFSR=SEED, counter=0, rail=0, last_rail=0, rail_valid=0, FIFO empty (tx_valid=0, tx_data=0), overflow=0. Reset is asynchronous, so assertion mid-operation flushes the queue at once.
- **LFSR.** Fibonacci LFSR, advances every clk regardless of enable. Maximal-length taps per width come from the package. If the state is all-zero, the next state is 1 (lock-up escape).
- **Tick counter.** Counts 0..TICK_DIV-1 while enable=1 and holds its value while enable=0. tick=1 in the cycle the counter equals TICK_DIV-1 with enable=1; the counter wraps to 0 on that cycle.
- **Rail draw on tick.**
  - cand = low RAIL_W LFSR bits; if cand ≥ NUM_RAILS, cand -= NUM_RAILS (one subtraction suffices).
  - If no_repeat=1 and cand == last_rail, cand = (cand+1) mod NUM_RAILS.
  - rail, last_rail ← cand.
- **Queue push on the same tick.** Byte = 8'h41 + cand.
  - Accepted if the FIFO is not full, or if it is full and a pop occurs that same cycle.
  - Otherwise the byte is dropped and overflow ← 1. rail and rail_valid are unaffected by a drop.
- **Pop.** Occurs on tx_valid && tx_ready. tx_data must hold stable while tx_valid=1 and tx_ready=0. Bytes leave in FIFO order.
- **Clearing overflow.** Only reset clears it.

## Timing
- tick in cycle T → rail, rail_valid=1, and the FIFO write are all visible in cycle T+1. rail_valid lasts exactly one cycle.
- With the FIFO empty, tx_valid rises in T+1 with tx_data = 8'h41+rail.
- Pop in cycle P → the next head (or tx_valid=0) is visible in P+1.
- After reset release with enable=1, the first rail_valid occurs in cycle TICK_DIV, counting the first enabled cycle as 0.
- FIFO pointers are LFSR-free, wrap modulo FIFO_DEPTH, and use an extra MSB for the full/empty distinction.

## Structure
- **Package tile_pkg:**
  - lfsr_taps(width) function: 8:{8,6,5,4}, 9:{9,5}, 10:{10,7}, 11:{11,9}, 12:{12,6,4,1}, 13:{13,4,3,1}, 14:{14,5,3,1}, 15:{15,14}, 16:{16,15,13,4}.
  - ASCII_BASE = 8'h41.
  - clog2 helper.
- **Sub-module tile_fifo:** parametrised synchronous show-ahead FIFO with push/pop/full/empty. The top contains the LFSR, the divider and the draw logic.

## Test plan
- **Pacing.** TICK_DIV=4, NUM_RAILS=4, tx_ready=1, enable=1 → rail_valid in cycles 4, 8, 12…; each followed by tx_valid for one cycle with tx_data = 8'h41+rail; matches a golden LFSR model from SEED.
- **Backpressure.** tx_ready=0, FIFO_DEPTH=4 → 4 spawns queued; the 5th still pulses rail_valid but sets overflow=1. Then tx_ready=1 → exactly the first 4 bytes emerge in order, then tx_valid=0; overflow stays 1.
- **Non-power-of-2 rails.** NUM_RAILS=3, 300 ticks → rail never equals 3; values 0, 1 and 2 all observed.
- **No-repeat.** no_repeat=1, NUM_RAILS=2, 100 ticks → rails strictly alternate. Toggling no_repeat=0 allows repeats matching the model.
- **Enable and lock-up.** enable=0 for 20 cycles mid-count → no spawn, counter holds, and the next spawn comes after the remaining count. With SEED=0, the LFSR equals 1 one cycle after reset release.
- **Reset mid-queue.** reset_n pulsed low with 3 bytes queued → tx_valid=0, overflow=0, rail=0 during reset; after release the queue is empty and the first spawn comes TICK_DIV cycles later.
